pipe_trace_buffer: RTL

//  Parametrised on-chip trace capture for the pipelined cpu: records NUM_CH pipeline

---
 rtl/pipe_trace_buffer_pkg.sv | 19 +
 rtl/pipe_trace_buffer_ram.sv | 35 +++
 rtl/pipe_trace_buffer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types for the pipeline trace buffer.
// TRACE_CYCLE_STAMP_EN selects whether each entry carries a cycle stamp in its MSBs.
package pipe_trace_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

`ifdef TRACE_CYCLE_STAMP_EN
    localparam int unsigned STAMP_EN = 1;
`else
    localparam int unsigned STAMP_EN = 0;
`endif

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module pipe_trace_buffer_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value when re is low, which gives the readout skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Trace capture of NUM_CH pipeline channels into a circular buffer, read out oldest-first.
// Optional TRACE_CYCLE_STAMP_EN prepends a free-running cycle stamp to every entry.
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned CYCLE_W = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        arm,
    input  logic                                        cap_en,
    input  logic [NUM_CH*DATA_W-1:0]                    ch_data,
    input  logic [DATA_W-1:0]                           trig_val,
    input  logic [DATA_W-1:0]                           trig_mask,
    input  logic [$clog2(DEPTH)-1:0]                    post_cnt,
    input  logic                                        rd_ready,
    output logic                                        rd_valid,
    output logic [NUM_CH*DATA_W+STAMP_EN*CYCLE_W-1:0]   rd_data,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        wrapped
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned FW      = AW + 1;
    localparam int unsigned ENTRY_W = NUM_CH*DATA_W + STAMP_EN*CYCLE_W;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [FW-1:0]   fill, fill_nxt;
    logic [AW-1:0]   post_left, post_left_nxt;
    logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [FW-1:0]   remaining, remaining_nxt;
    logic            wrapped_nxt, rd_valid_nxt, busy_nxt, done_nxt;
    logic            we_c, re_c, trig_c;
    logic [ENTRY_W-1:0] wdata_c;

    assign trig_c = cap_en && (((ch_data[DATA_W-1:0] ^ trig_val) & trig_mask) == '0);

`ifdef TRACE_CYCLE_STAMP_EN
    logic [CYCLE_W-1:0] stamp;

    // Free-running stamp; restarts at each arm so stamps are relative to capture start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp <= '0;
        end else if (arm) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + CYCLE_W'(1);
        end
    end

    assign wdata_c = {stamp, ch_data};
`else
    assign wdata_c = ch_data;
`endif

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            post_left <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            wrapped   <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            fill      <= fill_nxt;
            post_left <= post_left_nxt;
            rd_ptr    <= rd_ptr_nxt;
            remaining <= remaining_nxt;
            wrapped   <= wrapped_nxt;
            rd_valid  <= rd_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state, capture and readout control.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        fill_nxt      = fill;
        post_left_nxt = post_left;
        rd_ptr_nxt    = rd_ptr;
        remaining_nxt = remaining;
        wrapped_nxt   = wrapped;
        rd_valid_nxt  = rd_valid;
        we_c          = 1'b0;
        re_c          = 1'b0;

        case (state)
            ST_IDLE: begin
            end
            ST_ARMED: begin
                we_c = cap_en;
                if (trig_c) begin
                    post_left_nxt = post_cnt;
                    state_nxt     = (post_cnt == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (cap_en) begin
                    we_c          = 1'b1;
                    post_left_nxt = post_left - AW'(1);
                    if (post_left == AW'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                rd_ptr_nxt    = wrapped ? wr_ptr : '0;
                remaining_nxt = fill;
                state_nxt     = ST_READ;
            end
            ST_READ: begin
                // Fetch the next entry whenever the output register is empty or being drained.
                re_c = (remaining != '0) && (!rd_valid || rd_ready);
                if (re_c) begin
                    rd_ptr_nxt    = rd_ptr + AW'(1);
                    remaining_nxt = remaining - FW'(1);
                end
                rd_valid_nxt = re_c || (rd_valid && !rd_ready);
                if (rd_valid && rd_ready && (remaining == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (we_c) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
            if (fill != FW'(DEPTH)) begin
                fill_nxt = fill + FW'(1);
            end
            if (wr_ptr == AW'(DEPTH - 1)) begin
                wrapped_nxt = 1'b1;
            end
        end

        // Arm overrides everything, including a trigger in the same cycle.
        if (arm) begin
            state_nxt     = ST_ARMED;
            wr_ptr_nxt    = '0;
            fill_nxt      = '0;
            wrapped_nxt   = 1'b0;
            rd_valid_nxt  = 1'b0;
            remaining_nxt = '0;
            we_c          = 1'b0;
            re_c          = 1'b0;
        end

        busy_nxt = (state_nxt == ST_ARMED) || (state_nxt == ST_POST);
        done_nxt = (state_nxt == ST_DONE) || (state_nxt == ST_READ);
    end

    pipe_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_c),
        .waddr (wr_ptr),
        .wdata (wdata_c),
        .re    (re_c),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
